alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/common.sv | 32 +++
 rtl/alu.sv | 40 ++++
 rtl/alu_arbiter.sv | 83 ++++++++
 tb/tb_alu_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared definitions for the ALU datapath and the blocks that wrap it:
// op encodings, requester count and the buffered result record.
package common;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_XOR   = 5'd2,
        ALU_OR    = 5'd3,
        ALU_AND   = 5'd4,
        ALU_SRL   = 5'd5,
        ALU_SRA   = 5'd6,
        ALU_SLL   = 5'd7,
        ALU_SLT   = 5'd8,
        ALU_SLTU  = 5'd9,
        ALU_EQ    = 5'd10,
        ALU_NE    = 5'd11,
        ALU_LT    = 5'd12,
        ALU_GE    = 5'd13,
        ALU_LTU   = 5'd14,
        ALU_GEU   = 5'd15,
        ALU_BIT_C = 5'd16
    } alu_op_e;

    localparam int NUM_REQ = 2;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } result_entry_t;

endpackage

// File: rtl/alu.sv
// Core combinational ALU: 32-bit arithmetic, logic, shifts and compares.
// Compare ops return 0/1 in bit 0; unknown op codes yield zero.
module alu
    import common::*;
(
    input  logic [4:0]  op,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] result
);

    logic [4:0] shamt;

    assign shamt = op2[4:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = op1 + op2;
            ALU_SUB:   result = op1 - op2;
            ALU_XOR:   result = op1 ^ op2;
            ALU_OR:    result = op1 | op2;
            ALU_AND:   result = op1 & op2;
            ALU_SRL:   result = op1 >> shamt;
            ALU_SRA:   result = $signed(op1) >>> shamt;
            ALU_SLL:   result = op1 << shamt;
            ALU_SLT:   result = {31'b0, $signed(op1) < $signed(op2)};
            ALU_SLTU:  result = {31'b0, op1 < op2};
            ALU_EQ:    result = {31'b0, op1 == op2};
            ALU_NE:    result = {31'b0, op1 != op2};
            ALU_LT:    result = {31'b0, $signed(op1) < $signed(op2)};
            ALU_GE:    result = {31'b0, $signed(op1) >= $signed(op2)};
            ALU_LTU:   result = {31'b0, op1 < op2};
            ALU_GEU:   result = {31'b0, op1 >= op2};
            ALU_BIT_C: result = op1 & ~op2;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU through a round-robin arbiter; results are
// buffered with their requester id in a 2-entry FIFO, oldest first.
module alu_arbiter
    import common::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0][31:0]  req_op1,
    input  logic [NUM_REQ-1:0][31:0]  req_op2,
    input  logic [NUM_REQ-1:0][4:0]   req_ops,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic                      resp_id,
    output logic [31:0]               resp_data
);

    // Handshake: a request moves on a rising edge with req_valid[i] &&
    // req_ready[i]; a result leaves on a rising edge with resp_valid &&
    // resp_ready. Ready never depends on operand or op values.
    logic          last_grant;
    logic          grant;
    logic          can_accept;
    logic          push;
    logic          pop;
    logic [1:0]    count;
    logic          wr_ptr;
    logic          rd_ptr;
    result_entry_t mem [2];
    logic [31:0]   alu_result;

    alu u_alu (
        .op     (req_ops[grant]),
        .op1    (req_op1[grant]),
        .op2    (req_op2[grant]),
        .result (alu_result)
    );

    always_comb begin
        grant = 1'b0;
        if (&req_valid)
            grant = ~last_grant;
        else if (req_valid[1])
            grant = 1'b1;
        // A full FIFO still accepts when its head leaves in the same cycle.
        can_accept = (count < 2'd2) || resp_ready;
        req_ready  = '0;
        if (!rst && can_accept && req_valid[grant])
            req_ready[grant] = 1'b1;
    end

    assign push       = |(req_valid & req_ready);
    assign resp_valid = (count != 2'd0);
    assign pop        = resp_valid && resp_ready;
    assign resp_id    = mem[rd_ptr].id;
    assign resp_data  = mem[rd_ptr].data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            last_grant <= 1'b1;
            mem[0]     <= '0;
            mem[1]     <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{id: grant, data: alu_result};
                wr_ptr      <= ~wr_ptr;
                last_grant  <= grant;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a queue-based reference of the arbiter/FIFO, a
// vector table of ALU ops, directed corner sequences and random traffic.
module tb_alu_arbiter;
    import common::*;

    logic             clk;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_op1;
    logic [1:0][31:0] req_op2;
    logic [1:0][4:0]  req_ops;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [31:0]      resp_data;

    alu_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_ops    (req_ops),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

    // scoreboard: {id, data} in expected output order
    logic [32:0] exp_q[$];
    logic        m_last;
    int          n_vec;
    int          n_err;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tab [19];

    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        int unsigned sh;
        sh = b % 32;
        r  = 32'd0;
        case (op)
            ALU_ADD:         r = a + b;
            ALU_SUB:         r = a - b;
            ALU_XOR:         r = a ^ b;
            ALU_OR:          r = a | b;
            ALU_AND:         r = a & b;
            ALU_SRL:         r = a >> sh;
            ALU_SRA:         r = $signed(a) >>> sh;
            ALU_SLL:         r = a << sh;
            ALU_SLT, ALU_LT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU, ALU_LTU: r = (a < b) ? 32'd1 : 32'd0;
            ALU_EQ:          r = (a == b) ? 32'd1 : 32'd0;
            ALU_NE:          r = (a != b) ? 32'd1 : 32'd0;
            ALU_GE:          r = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            ALU_GEU:         r = (a >= b) ? 32'd1 : 32'd0;
            ALU_BIT_C:       r = a & ~b;
            default:         r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of traffic: check outputs at the falling edge against the
    // model, then let the model follow the transfers of the rising edge.
    task automatic cycle();
        logic [1:0]  er;
        logic        g;
        logic        can;
        int          cnt;
        logic [32:0] head;
        @(negedge clk);
        cnt = exp_q.size();
        can = (cnt < 2) || resp_ready;
        if (req_valid == 2'b11) g = ~m_last;
        else                    g = req_valid[1];
        er = 2'b00;
        if (can && req_valid[g]) er[g] = 1'b1;
        chk("req_ready", {30'd0, req_ready}, {30'd0, er});
        chk("resp_valid", {31'd0, resp_valid}, (cnt != 0) ? 32'd1 : 32'd0);
        if (cnt != 0) begin
            head = exp_q[0];
            chk("resp_id", {31'd0, resp_id}, {31'd0, head[32]});
            chk("resp_data", resp_data, head[31:0]);
        end
        @(posedge clk);
        if (cnt != 0 && resp_ready) void'(exp_q.pop_front());
        if (er != 2'b00) begin
            exp_q.push_back({g, ref_alu(req_ops[g], req_op1[g], req_op2[g])});
            m_last = g;
        end
        #1;
    endtask

    task automatic drive(input int i, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        req_ops[i] = op;
        req_op1[i] = a;
        req_op2[i] = b;
    endtask

    task automatic do_reset();
        req_valid = 2'b00;
        rst = 1'b1;
        #1;
        exp_q.delete();
        m_last = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_last = 1'b1;
        rst = 1'b1;
        req_valid = 2'b11;
        resp_ready = 1'b0;
        req_op1 = '0;
        req_op2 = '0;
        req_ops = '0;

        tab[0]  = '{ALU_ADD,   32'd5,          32'd3,          32'd8};
        tab[1]  = '{ALU_ADD,   32'hFFFF_FFFF,  32'd2,          32'd1};
        tab[2]  = '{ALU_SUB,   32'd0,          32'd1,          32'hFFFF_FFFF};
        tab[3]  = '{ALU_XOR,   32'h0000_F0F0,  32'h0000_FF00,  32'h0000_0FF0};
        tab[4]  = '{ALU_OR,    32'h0000_F0F0,  32'h0000_0F0F,  32'h0000_FFFF};
        tab[5]  = '{ALU_AND,   32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000};
        tab[6]  = '{ALU_SRL,   32'h8000_0000,  32'd4,          32'h0800_0000};
        tab[7]  = '{ALU_SRA,   32'h8000_0000,  32'd4,          32'hF800_0000};
        tab[8]  = '{ALU_SLL,   32'd1,          32'd33,         32'd2};
        tab[9]  = '{ALU_SLT,   32'hFFFF_FFFF,  32'd1,          32'd1};
        tab[10] = '{ALU_SLTU,  32'hFFFF_FFFF,  32'd1,          32'd0};
        tab[11] = '{ALU_EQ,    32'd7,          32'd7,          32'd1};
        tab[12] = '{ALU_NE,    32'd7,          32'd7,          32'd0};
        tab[13] = '{ALU_LT,    32'hFFFF_FFFB,  32'd3,          32'd1};
        tab[14] = '{ALU_GE,    32'hFFFF_FFFF,  32'd0,          32'd0};
        tab[15] = '{ALU_LTU,   32'd3,          32'd5,          32'd1};
        tab[16] = '{ALU_GEU,   32'hFFFF_FFFF,  32'd0,          32'd1};
        tab[17] = '{ALU_BIT_C, 32'h0000_00FF,  32'h0000_000F,  32'h0000_00F0};
        tab[18] = '{5'h1F,     32'h1234_5678,  32'h0000_0001,  32'd0};

        // reset state, with both requesters asserting valid
        #12;
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_id", {31'd0, resp_id}, 32'd0);
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single requester, first edge after reset release
        resp_ready = 1'b1;
        drive(0, ALU_ADD, 32'd5, 32'd3);
        req_valid = 2'b01;
        cycle();
        req_valid = 2'b00;
        chk("single_valid", {31'd0, resp_valid}, 32'd1);
        chk("single_id", {31'd0, resp_id}, 32'd0);
        chk("single_data", resp_data, 32'd8);
        cycle();

        // contention from reset: grants alternate starting with requester 0
        do_reset();
        resp_ready = 1'b1;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            drive(0, ALU_ADD, 32'd100, k);
            drive(1, ALU_SUB, 32'd200, k);
            #1;
            chk("contention_grant", {30'd0, req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
            cycle();
        end
        req_valid = 2'b00;
        cycle();
        cycle();

        // backpressure: FIFO full blocks both requesters
        do_reset();
        resp_ready = 1'b0;
        drive(1, ALU_SUB, 32'd1, 32'd2);
        req_valid = 2'b10;
        cycle();
        drive(1, ALU_SLL, 32'd1, 32'd33);
        cycle();
        req_valid = 2'b11;
        #1;
        chk("bp_full_ready", {30'd0, req_ready}, 32'd0);
        cycle();
        req_valid = 2'b00;
        resp_ready = 1'b1;
        chk("bp_head_data", resp_data, 32'hFFFF_FFFF);
        chk("bp_head_id", {31'd0, resp_id}, 32'd1);
        cycle();
        chk("bp_second_data", resp_data, 32'd2);
        chk("bp_second_id", {31'd0, resp_id}, 32'd1);
        cycle();

        // simultaneous push and pop while full
        resp_ready = 1'b0;
        drive(0, ALU_ADD, 32'd10, 32'd1);
        req_valid = 2'b01;
        cycle();
        drive(0, ALU_ADD, 32'd20, 32'd2);
        cycle();
        resp_ready = 1'b1;
        drive(0, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        cycle();
        req_valid = 2'b00;
        chk("pushpop_valid", {31'd0, resp_valid}, 32'd1);
        chk("pushpop_second", resp_data, 32'd22);
        cycle();
        chk("pushpop_third", resp_data, 32'd1);
        cycle();

        // reset asserted between edges with the FIFO full
        resp_ready = 1'b0;
        drive(0, ALU_ADD, 32'd1, 32'd1);
        req_valid = 2'b01;
        cycle();
        cycle();
        req_valid = 2'b11;
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("midrst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("midrst_resp_data", resp_data, 32'd0);
        exp_q.delete();
        m_last = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 2'b01;
        resp_ready = 1'b1;
        drive(0, ALU_ADD, 32'd10, 32'd20);
        cycle();
        req_valid = 2'b00;
        chk("midrst_first_data", resp_data, 32'd30);
        cycle();

        // op table, alternating requesters
        for (int k = 0; k < 19; k++) begin
            drive(k % 2, tab[k].op, tab[k].a, tab[k].b);
            req_valid = (k % 2 == 0) ? 2'b01 : 2'b10;
            resp_ready = 1'b1;
            cycle();
            req_valid = 2'b00;
            chk($sformatf("tab%0d_data", k), resp_data, tab[k].exp);
            cycle();
        end

        // random traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++) begin
                drive(i, 5'($urandom_range(0, 19)),
                      ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom(),
                      ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom());
            end
            req_valid = 2'($urandom_range(0, 3));
            resp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        req_valid = 2'b00;
        resp_ready = 1'b1;
        cycle();
        cycle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
